nios_system_sysid_ext: RTL and testbench
========================================

Name: nios_system_sysid_ext

Overview:
Parametrised successor to the constant system-ID slave: a single Avalon-MM slave on the Nios system interconnect.
- Identity: read-only ID and build timestamp words.
- Uptime: a 64-bit free-running counter with atomic low/high read.
- Scratch: two read/write words with byteenable.
- Heartbeat: a prescaled toggle output for a board LED.
- Read timing: fixed, parametrised latency, signalled with readdatavalid; no waitrequest.

Parameters:
SYSTEM_ID, 32'hCAFE0001, value of register 0
TIMESTAMP, 32'h00000000, build time (Unix seconds), value of register 1
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal 1..4
HB_DIV, 50000000, heartbeat half-period in clocks; legal >= 2

Ports:
clock  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous assert, active-low reset
address  in  3  word offset
read  in  1  read strobe, accepted every cycle it is high
write  in  1  write strobe, accepted every cycle it is high
writedata  in  32  write data
byteenable  in  4  byte lanes for writedata
readdata  out  32  read data; 0 when readdatavalid low
readdatavalid  out  1  read data qualifier
heartbeat  out  1  LED toggle

Behaviour:
Reset: one clock, asynchronous active-low reset named reset_n.
- Reset values: readdata=0, readdatavalid=0, heartbeat=0, read pipeline flushed.
- Register reset values: uptime=0, scratch=0, hb_en=1, wrap=0, prescaler=0.
- Reset asserted mid-read: the pending read is dropped; readdatavalid is never issued for it.

Register map (word offsets):
- 0 ID: RO, SYSTEM_ID.
- 1 TIMESTAMP: RO, TIMESTAMP.
- 2 UPTIME_LO: RW.
  - Read returns counter[31:0] and loads shadow_hi <= counter[63:32] in the same cycle.
  - Write loads counter[31:0] (byteenable honoured).
- 3 UPTIME_HI: RW.
  - Read returns shadow_hi.
  - Write loads counter[63:32] (byteenable honoured).
- 4, 5 SCRATCH0/1: RW, byteenable per lane.
- 6 CTRL:
  - bit0 hb_en: RW.
  - bit1 clr: write 1 clears counter; always reads 0.
  - bit8 wrap: sticky; write 1 clears.
  - All other bits read 0.
- 7: reserved; reads 0, writes ignored.

Read pipeline:
- Data is sampled in the acceptance cycle N.
- readdata and readdatavalid are asserted in cycle N+READ_LATENCY for exactly one cycle.
- Back-to-back reads are fully pipelined: one result per cycle, in order.

Write/read collision: same-cycle read and write is illegal per Avalon. If it occurs, the write takes effect and the read returns the pre-write value.

Uptime counter:
- Increments by 1 every clock.
- Priority: clr > preload write (LO or HI) > increment.
- A preload of one half leaves the other half unchanged and suppresses the increment that cycle.
- Wrap 0xFFFF_FFFF_FFFF_FFFF -> 0 sets wrap.
  - A W1C of wrap in the same cycle as a wrap event leaves wrap set.

Heartbeat:
- hb_en=1: prescaler counts 0..HB_DIV-1. On reaching HB_DIV-1 it returns to 0 and heartbeat toggles.
- hb_en=0: prescaler is held at 0 and heartbeat holds its current level.

Optional Feature:
SYSID_UPTIME_EN
- Defined: uptime counter, shadow_hi and the wrap flag are built as described above.
- Undefined: none of these registers exist.
  - Offsets 2 and 3 read 0; writes to them are ignored.
  - CTRL.clr is ignored and CTRL.wrap reads 0.
  - ID, TIMESTAMP, scratch, heartbeat and read latency are unchanged.

Test Plan:
1. Reset and identity: release reset, then read offsets 0 and 1 at READ_LATENCY=3 -> readdatavalid 3 cycles after each read; data 0xCAFE0001, then TIMESTAMP. readdata=0 between valids.
2. Back-to-back reads: reads of 0,4,7,6 on consecutive cycles -> four consecutive valids in order: 0xCAFE0001, 0, 0, 0x00000001.
3. Atomic uptime and wrap (SYSID_UPTIME_EN):
   - Write HI=0xFFFFFFFF, then LO=0xFFFFFFFE.
   - Read LO, then HI, with a 10-cycle gap -> HI returns the value latched at the LO read, not the later counter.
   - After the wrap, CTRL bit8=1. Write 0x100 to CTRL -> bit8 reads 0.
4. Scratch byteenable: write 0xAABBCCDD with be=4'b0101 to offset 4 (scratch reset 0) -> reads 0x00BB00DD.
5. Clear priority: same cycle issue CTRL.clr=1 and, one cycle later, a LO preload; then read LO -> counter holds the preload value plus elapsed cycles. Clear alone -> LO reads small (< READ_LATENCY + 3).
6. Heartbeat: HB_DIV=4 -> heartbeat toggles every 4 clocks. Write hb_en=0 -> level frozen for 20 cycles. Re-enable -> first toggle exactly 4 clocks later.
   - Assert reset_n low mid-read -> no readdatavalid for the dropped read.

Source files
------------

// File: rtl/nios_system_sysid_ext.sv
// System-ID Avalon-MM slave: ID/timestamp, uptime counter, scratch words, heartbeat LED.
// Define SYSID_UPTIME_EN to build the 64-bit uptime counter, its shadow and the wrap flag.
module nios_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID    = 32'hCAFE0001,
  parameter logic [31:0] TIMESTAMP    = 32'h00000000,
  parameter int          READ_LATENCY = 1,
  parameter int          HB_DIV       = 50000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        heartbeat
);

  localparam int PW = $clog2(HB_DIV);
  localparam logic [PW-1:0] PRESC_TC = PW'(HB_DIV - 1);

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  logic        wr_ctrl;
  logic [31:0] scratch0_q, scratch0_d;
  logic [31:0] scratch1_q, scratch1_d;
  logic        hb_en_q, hb_en_d;
  logic [PW-1:0] presc_q, presc_d;
  logic        hb_q, hb_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0] dat_q [READ_LATENCY];
  logic [31:0] dat_d [READ_LATENCY];
  logic [31:0] rd_mux;
  logic [31:0] up_lo;
  logic [31:0] up_hi;
  logic        wrap_bit;

  assign wr_ctrl = write && (address == 3'd6);

`ifdef SYSID_UPTIME_EN
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        wrap_q, wrap_d;
  logic        wr_lo, wr_hi, rd_lo, clr;

  assign wr_lo = write && (address == 3'd2);
  assign wr_hi = write && (address == 3'd3);
  assign rd_lo = read && (address == 3'd2);
  assign clr   = wr_ctrl && byteenable[0] && writedata[1];

  always_comb begin
    cnt_d    = cnt_q + 64'd1;
    shadow_d = shadow_q;
    wrap_d   = wrap_q;
    if (wr_ctrl && byteenable[1] && writedata[8]) wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_lo) begin
      cnt_d = {cnt_q[63:32], be_merge(cnt_q[31:0], writedata, byteenable)};
    end else if (wr_hi) begin
      cnt_d = {be_merge(cnt_q[63:32], writedata, byteenable), cnt_q[31:0]};
    end else if (cnt_q == '1) begin
      // a wrap event wins over a same-cycle W1C
      wrap_d = 1'b1;
    end
    if (rd_lo) shadow_d = cnt_q[63:32];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      wrap_q   <= wrap_d;
    end
  end

  assign up_lo    = cnt_q[31:0];
  assign up_hi    = shadow_q;
  assign wrap_bit = wrap_q;
`else
  assign up_lo    = '0;
  assign up_hi    = '0;
  assign wrap_bit = 1'b0;
`endif

  always_comb begin
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    hb_en_d    = hb_en_q;
    presc_d    = presc_q;
    hb_d       = hb_q;
    rd_mux     = '0;

    if (write && address == 3'd4) scratch0_d = be_merge(scratch0_q, writedata, byteenable);
    if (write && address == 3'd5) scratch1_d = be_merge(scratch1_q, writedata, byteenable);
    if (wr_ctrl && byteenable[0]) hb_en_d = writedata[0];

    if (!hb_en_q) begin
      presc_d = '0;
    end else if (presc_q == PRESC_TC) begin
      presc_d = '0;
      hb_d    = ~hb_q;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // sampled from current state, so a colliding write is not visible to the read
    case (address)
      3'd0:    rd_mux = SYSTEM_ID;
      3'd1:    rd_mux = TIMESTAMP;
      3'd2:    rd_mux = up_lo;
      3'd3:    rd_mux = up_hi;
      3'd4:    rd_mux = scratch0_q;
      3'd5:    rd_mux = scratch1_q;
      3'd6:    rd_mux = {23'd0, wrap_bit, 7'd0, hb_en_q};
      default: rd_mux = '0;
    endcase

    vld_d[0] = read;
    dat_d[0] = read ? rd_mux : '0;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch0_q <= '0;
      scratch1_q <= '0;
      hb_en_q    <= 1'b1;
      presc_q    <= '0;
      hb_q       <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      hb_en_q    <= hb_en_d;
      presc_q    <= presc_d;
      hb_q       <= hb_d;
      vld_q      <= vld_d;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign readdata      = vld_q[READ_LATENCY-1] ? dat_q[READ_LATENCY-1] : '0;
  assign heartbeat     = hb_q;

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Scoreboard bench for nios_system_sysid_ext at READ_LATENCY=3, HB_DIV=4.
module tb_nios_system_sysid_ext;
  localparam int          RL  = 3;
  localparam int          HB  = 4;
  localparam logic [31:0] SYS = 32'hCAFE0001;
  localparam logic [31:0] TS  = 32'h65001234;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        heartbeat;

  nios_system_sysid_ext #(
    .SYSTEM_ID(SYS), .TIMESTAMP(TS), .READ_LATENCY(RL), .HB_DIV(HB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid), .heartbeat(heartbeat)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t sbq[$];
  exp_t e;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int hb_tog = 0;
  int hb_t_last = 0;
  logic hb_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (readdatavalid) begin
      if (sbq.size() == 0) begin
        chk("spurious_vld", readdatavalid, 0);
      end else begin
        e = sbq.pop_front();
        chk("rd_data", readdata, e.data);
        chk("rd_lat", cyc, e.due);
      end
    end else begin
      chk("rd_idle_zero", readdata, 0);
      if (sbq.size() != 0 && sbq[0].due < cyc) begin
        chk("rd_missing", readdatavalid, 1);
        void'(sbq.pop_front());
      end
    end
    if (heartbeat !== hb_prev) begin
      hb_tog++;
      hb_t_last = cyc;
    end
    hb_prev = heartbeat;
  end

  task automatic idle();
    @(posedge clock);
    #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_rd(input logic [2:0] a, input logic [31:0] exp);
    @(negedge clock);
    sbq.push_back('{data: exp, due: cyc + RL});
    address = a; read = 1'b1; write = 1'b0;
    idle();
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                        output int t);
    @(negedge clock);
    t = cyc;
    address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
    idle();
  endtask

  task automatic do_rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp_old);
    @(negedge clock);
    sbq.push_back('{data: exp_old, due: cyc + RL});
    address = a; writedata = d; byteenable = 4'hF; write = 1'b1; read = 1'b1;
    idle();
  endtask

  // counter preloaded to p at the edge after tw; LO read sampled cyc-tw-1 edges later
  task automatic rd_up_lo(input int tw, input logic [63:0] p, output logic [63:0] v);
    @(negedge clock);
    v = p + 64'(cyc - tw - 1);
    sbq.push_back('{data: v[31:0], due: cyc + RL});
    address = 3'd2; read = 1'b1; write = 1'b0;
    idle();
  endtask

  task automatic wait_tog(input int n0);
    for (int i = 0; i < 12 && hb_tog == n0; i++) begin
      @(negedge clock);
      #1;
    end
    chk("hb_seen", hb_tog != n0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, n0;
    logic lvl;
    logic [63:0] v;

    repeat (3) @(negedge clock);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_rd", readdata, 0);
    chk("rst_hb", heartbeat, 0);
    reset_n = 1'b1;
    idle();

    // identity, with gaps so idle readdata is observed between valids
    do_rd(3'd0, SYS);
    repeat (2) idle();
    do_rd(3'd1, TS);
    repeat (5) idle();

    // back-to-back
    do_rd(3'd0, SYS);
    do_rd(3'd4, 32'h0);
    do_rd(3'd7, 32'h0);
    do_rd(3'd6, 32'h1);
    repeat (5) idle();

    // scratch byte lanes, reserved write ignored, collision
    bus_wr(3'd4, 32'hAABBCCDD, 4'b0101, t);
    do_rd(3'd4, 32'h00BB00DD);
    bus_wr(3'd5, 32'h11223344, 4'hF, t);
    bus_wr(3'd5, 32'h55667788, 4'b1000, t);
    bus_wr(3'd7, 32'hFFFFFFFF, 4'hF, t);
    do_rd(3'd5, 32'h55223344);
    do_rd(3'd7, 32'h0);
    do_rdwr(3'd5, 32'h0BADF00D, 32'h55223344);
    do_rd(3'd5, 32'h0BADF00D);
    repeat (5) idle();

`ifdef SYSID_UPTIME_EN
    bus_wr(3'd3, 32'hFFFFFFFF, 4'hF, t);
    bus_wr(3'd2, 32'hFFFFFFFE, 4'hF, t);
    rd_up_lo(t, 64'hFFFFFFFF_FFFFFFFE, v);
    repeat (10) idle();
    do_rd(3'd3, v[63:32]);
    do_rd(3'd6, 32'h101);
    bus_wr(3'd6, 32'h100, 4'hF, t);
    do_rd(3'd6, 32'h0);
    bus_wr(3'd6, 32'h1, 4'hF, t);
    repeat (5) idle();

    // clear then LO preload, HI stays cleared
    bus_wr(3'd6, 32'h3, 4'hF, t1);
    bus_wr(3'd2, 32'h1000, 4'hF, t);
    repeat (3) idle();
    rd_up_lo(t, 64'h1000, v);
    do_rd(3'd3, 32'h0);
    bus_wr(3'd6, 32'h3, 4'hF, t);
    rd_up_lo(t, 64'h0, v);
    chk("clr_small", v < 64'(RL + 3), 1);
    repeat (5) idle();
`else
    do_rd(3'd2, 32'h0);
    do_rd(3'd3, 32'h0);
    bus_wr(3'd2, 32'hFFFFFFFF, 4'hF, t);
    bus_wr(3'd3, 32'hFFFFFFFF, 4'hF, t);
    do_rd(3'd2, 32'h0);
    do_rd(3'd3, 32'h0);
    bus_wr(3'd6, 32'h103, 4'hF, t);
    do_rd(3'd6, 32'h1);
    repeat (5) idle();
`endif

    // heartbeat period
    wait_tog(hb_tog);
    for (int k = 0; k < 3; k++) begin
      t1 = hb_t_last;
      wait_tog(hb_tog);
      chk("hb_period", hb_t_last - t1, HB);
    end

    // freeze, then re-enable
    bus_wr(3'd6, 32'h0, 4'hF, t);
    @(negedge clock);
    #1;
    lvl = heartbeat;
    n0 = hb_tog;
    repeat (20) @(negedge clock);
    #1;
    chk("hb_frz_lvl", heartbeat, lvl);
    chk("hb_frz_cnt", hb_tog - n0, 0);
    do_rd(3'd6, 32'h0);
    repeat (4) idle();
    n0 = hb_tog;
    bus_wr(3'd6, 32'h1, 4'hF, t);
    wait_tog(n0);
    chk("hb_reen", hb_t_last, t + 1 + HB);
    repeat (3) idle();

    // reset while a read is in flight: it must never complete
    do_rd(3'd0, SYS);
    @(negedge clock);
    reset_n = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clock);
    chk("rst_mid_hb", heartbeat, 0);
    reset_n = 1'b1;
    repeat (RL + 4) @(negedge clock);
    do_rd(3'd4, 32'h0);
    do_rd(3'd6, 32'h1);
    do_rd(3'd0, SYS);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clock);
    chk("drain", sbq.size(), 0);
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
